// File: rtl/sram_cache_drain_if.sv
// Bus bundle between the drain engine, the cache read port and the stream sink.
// The master side is the drain engine; the slave side is the cache plus the sink.
interface sram_cache_drain_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_en;
  logic                  r_data_en;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tvalid;
  logic                  m_tlast;
  logic                  m_tready;

  modport master (
    output r_addr, r_en, r_data_en, m_tdata, m_tvalid, m_tlast,
    input  r_data, m_tready
  );

  modport slave (
    input  r_addr, r_en, r_data_en, m_tdata, m_tvalid, m_tlast,
    output r_data, m_tready
  );
endinterface

// File: rtl/sram_cache_drain.sv
// Read-side drain engine for the shared DMA cache. Reads a run of words from
// a base address (wrapping at the top of the cache), hides the fixed SRAM read
// latency with a tag pipeline, and buffers the words in a small FIFO that feeds
// a valid/ready stream with full backpressure. Reads are only issued when the
// FIFO is guaranteed to have room for them once they land.
module sram_cache_drain #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  sram_cache_drain_if.master    bus
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
  localparam logic [CW-1:0]       DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0]       LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_ctr;
  logic [ADDR_WIDTH:0]     issue_ctr;
  logic [ADDR_WIDTH:0]     out_ctr;
  logic [RD_LATENCY-1:0]   pipe;
  logic [CW-1:0]           inflight;
  logic [CW-1:0]           fifo_count;
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           wr_ptr;
  logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
  logic                    done_r;

  logic                    credit_ok;
  logic                    issue;
  logic                    push;
  logic                    pop;
  logic                    fifo_valid;

  // Words in flight plus words buffered must leave room for one more read.
  assign credit_ok  = (inflight + fifo_count) < DEPTH_C;
  assign issue      = (state == ISSUE) && (issue_ctr != '0) && credit_ok;
  assign push       = pipe[RD_LATENCY-1];
  assign fifo_valid = (fifo_count != '0);
  assign pop        = fifo_valid && bus.m_tready;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort outranks everything once a transfer is running.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start && (length != '0)) state_nxt = ISSUE;
      ISSUE:   if (abort) state_nxt = IDLE;
               else if (issue && (issue_ctr == CNT_ONE)) state_nxt = DRAIN;
      DRAIN:   if (abort) state_nxt = IDLE;
               else if (pop && bus.m_tlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; stream data is forced to zero whenever the FIFO is empty.
  always_comb begin
    busy          = (state != IDLE);
    done          = done_r;
    bus.r_en      = issue;
    bus.r_addr    = addr_ctr;
    bus.r_data_en = 1'b1;
    bus.m_tvalid  = fifo_valid;
    bus.m_tdata   = fifo_valid ? fifo_mem[rd_ptr] : '0;
    bus.m_tlast   = fifo_valid && (out_ctr == CNT_ONE);
  end

  // Counters, read-tag pipeline, FIFO bookkeeping and the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_ctr   <= '0;
      issue_ctr  <= '0;
      out_ctr    <= '0;
      pipe       <= '0;
      inflight   <= '0;
      fifo_count <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          if (length == '0) begin
            done_r <= 1'b1;
          end else begin
            addr_ctr  <= base_addr;
            issue_ctr <= length;
            out_ctr   <= length;
          end
        end
      end else if (abort) begin
        pipe       <= '0;
        inflight   <= '0;
        fifo_count <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        issue_ctr  <= '0;
        done_r     <= 1'b1;
      end else begin
        pipe[0] <= issue;
        for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
        if (issue) begin
          addr_ctr  <= addr_ctr + ADDR_WIDTH'(1);
          issue_ctr <= issue_ctr - CNT_ONE;
        end
        if (push) wr_ptr <= ptr_next(wr_ptr);
        if (pop) begin
          rd_ptr  <= ptr_next(rd_ptr);
          out_ctr <= out_ctr - CNT_ONE;
        end
        unique case ({issue, push})
          2'b10:   inflight <= inflight + CW'(1);
          2'b01:   inflight <= inflight - CW'(1);
          default: inflight <= inflight;
        endcase
        unique case ({push, pop})
          2'b10:   fifo_count <= fifo_count + CW'(1);
          2'b01:   fifo_count <= fifo_count - CW'(1);
          default: fifo_count <= fifo_count;
        endcase
        if (pop && bus.m_tlast) done_r <= 1'b1;
      end
    end
  end

  // FIFO storage; stale entries are harmless because the count gates visibility.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.r_data;
  end

endmodule

// File: doc/sram_cache_drain.md
Name: sram_cache_drain

Overview:
- Read-side engine for the DMA controller's 256x32 two-port SRAM cache; the write-side filler and the drain share one cache.
- On START it reads LENGTH words from BASE_ADDR upward, with wrap-around.
- Hides the SRAM's fixed read latency and presents the words as an AXI-Stream-style valid/ready output with full backpressure support.
- Sits between the cache read port and the DMA write-out master.

Parameters:
- ADDR_WIDTH, 8, cache word-address width (depth 2^ADDR_WIDTH).
- DATA_WIDTH, 32, cache word width.
- RD_LATENCY, 2, cycles from an R_EN=1 edge to valid R_DATA (legal values 1 or 2).
- FIFO_DEPTH, 4, output buffer depth; must be at least RD_LATENCY+2.

Ports:
- CLK  in  1  single clock; all logic rises on it.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle request; sampled only in IDLE.
- BASE_ADDR  in  ADDR_WIDTH  first word address; captured on START.
- LENGTH  in  ADDR_WIDTH+1  word count, 0..256; captured on START.
- ABORT  in  1  terminates the transfer; highest priority.
- BUSY  out  1  high from the cycle after START until DONE.
- DONE  out  1  one-cycle pulse when the transfer ends (normal or aborted).
- R_ADDR  out  ADDR_WIDTH  cache read address.
- R_EN  out  1  cache read enable; one word per cycle when high.
- R_DATA_EN  out  1  cache output-register enable.
- R_DATA  in  DATA_WIDTH  cache read data.
- M_TDATA  out  DATA_WIDTH  stream data.
- M_TVALID  out  1  stream valid.
- M_TLAST  out  1  marks the final word.
- M_TREADY  in  1  sink ready.

Behaviour:
- Reset values: BUSY=0, DONE=0, R_EN=0, R_ADDR=0, R_DATA_EN=1, M_TVALID=0, M_TLAST=0, M_TDATA=0. The FSM enters IDLE and the FIFO and counters clear.
- R_DATA_EN is held at 1 at all times outside reset.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - START=1 with LENGTH>0: capture BASE_ADDR into addr_ctr and LENGTH into issue_ctr and out_ctr, then go to ISSUE.
  - START=1 with LENGTH=0: pulse DONE next cycle, no reads, BUSY stays 0.
- ISSUE:
  - R_EN=1 and R_ADDR=addr_ctr on any cycle where issue_ctr>0 and (inflight + fifo_count) < FIFO_DEPTH. This credit rule guarantees the FIFO never overflows.
  - On each issue: addr_ctr increments modulo 2^ADDR_WIDTH (0xFF wraps to 0x00), issue_ctr decrements, inflight increments.
  - Go to DRAIN when the last read is issued.
- Read pipeline: a shift register of depth RD_LATENCY tracks the issued R_EN. When its tail is 1, R_DATA is pushed into the FIFO and inflight decrements. If an issue and a push happen in the same cycle, inflight stays unchanged.
- Output:
  - M_TVALID = FIFO not empty; M_TDATA = FIFO head.
  - A pop occurs when M_TVALID and M_TREADY are both 1; out_ctr decrements on each pop.
  - M_TLAST = M_TVALID and out_ctr==1.
  - M_TDATA and M_TLAST hold stable while M_TVALID=1 and M_TREADY=0.
- DRAIN: issues nothing. On the pop of the TLAST word, go to IDLE and pulse DONE in the following cycle.
- Throughput: with M_TREADY held at 1, one word per cycle sustained. The first M_TVALID appears RD_LATENCY+1 cycles after the START edge.
- START in ISSUE or DRAIN is ignored.
- ABORT (any non-IDLE state):
  - Next cycle: R_EN=0, FIFO flushed, pipeline tags cleared, M_TVALID=0, DONE pulses, FSM goes to IDLE.
  - Read data still in flight is discarded.
- ABORT and START in the same cycle in IDLE: START wins, because ABORT has no effect in IDLE.
- RESET mid-transfer returns everything to reset values immediately (asynchronously).
- BUSY = (state != IDLE).

Test Plan:
1. Basic read: cache preloaded with mem[i]=0xA000_0000+i; START, BASE=0x10, LEN=4, TREADY=1. Expect words 0xA000_0010..0xA000_0013 on consecutive cycles, TLAST on 0x13, DONE one cycle after the last pop, R_EN high for exactly 4 cycles.
2. Wrap: BASE=0xFE, LEN=4. Expect R_ADDR sequence FE, FF, 00, 01 and stream data mem[FE], mem[FF], mem[00], mem[01].
3. Backpressure: LEN=16, TREADY toggled 1-0-0-1 randomly. Expect no word lost or duplicated, TDATA stable while stalled, and inflight+fifo_count never above 4.
4. Zero length: START with LEN=0. Expect DONE pulse next cycle, R_EN never asserted, M_TVALID never asserted, BUSY=0.
5. Abort: LEN=256, TREADY=0; ABORT after 10 cycles. Expect M_TVALID=0 the next cycle, DONE one pulse, BUSY=0. A following START with BASE=0, LEN=2 returns mem[0], mem[1] cleanly.
6. Full range plus reset: LEN=256 streams all 256 words with TLAST only on the last. Asserting RESET mid-stream drops all outputs to reset values at once, and a START after reset release works normally.
